// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: latches E-stage operands, runs a fixed-latency
// busy window, commits HI/LO and stalls D-stage MDU instructions while a result is in flight.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  e_mdu_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_is_mdu,
  output logic [31:0] md_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        start,
  output logic        stall
);

  typedef enum logic [1:0] {StIdle, StMulBusy, StDivBusy} state_e;

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMfhi  = 4'd7;
  localparam logic [3:0] OpMflo  = 4'd8;

  localparam logic [3:0] MulLoad = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DivLoad = 4'(DIV_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] a_q, b_q;
  logic        signed_q;
  logic [31:0] hi_q, lo_q;
  logic        busy_q;

  logic        is_muldiv;
  logic        idle;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] abs_a, abs_b, uquot, urem, quot, rem;

  assign idle      = (state_q == StIdle);
  assign is_muldiv = (e_mdu_op >= OpMult) && (e_mdu_op <= OpDivu);
  assign start     = is_muldiv & ~req & idle;
  assign stall     = d_is_mdu & (busy_q | start);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;

  always_comb begin
    md_rdata = 32'd0;
    if (e_mdu_op == OpMfhi) md_rdata = hi_q;
    else if (e_mdu_op == OpMflo) md_rdata = lo_q;
  end

  // One 64x64 multiplier serves both signednesses; the low 64 bits are exact either way.
  assign a_ext = signed_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign b_ext = signed_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod  = a_ext * b_ext;

  // Signed division via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    abs_a = (signed_q && a_q[31]) ? (~a_q + 32'd1) : a_q;
    abs_b = (signed_q && b_q[31]) ? (~b_q + 32'd1) : b_q;
    uquot = 32'd0;
    urem  = 32'd0;
    if (abs_b != 32'd0) begin
      uquot = abs_a / abs_b;
      urem  = abs_a % abs_b;
    end
    quot = (signed_q && (a_q[31] ^ b_q[31])) ? (~uquot + 32'd1) : uquot;
    rem  = (signed_q && a_q[31]) ? (~urem + 32'd1) : urem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      signed_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q      <= e_rs;
            b_q      <= e_rt;
            signed_q <= (e_mdu_op == OpMult) || (e_mdu_op == OpDiv);
            busy_q   <= 1'b1;
            if ((e_mdu_op == OpMult) || (e_mdu_op == OpMultu)) begin
              cnt_q   <= MulLoad;
              state_q <= StMulBusy;
            end else begin
              cnt_q   <= DivLoad;
              state_q <= StDivBusy;
            end
          end else if (!req && e_mdu_op == OpMthi) begin
            hi_q <= e_rs;
          end else if (!req && e_mdu_op == OpMtlo) begin
            lo_q <= e_rs;
          end
        end
        StMulBusy: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            hi_q    <= prod[63:32];
            lo_q    <= prod[31:0];
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StDivBusy: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // Divide by zero leaves HI/LO untouched.
            if (b_q != 32'd0) begin
              hi_q <= rem;
              lo_q <= quot;
            end
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with hand-computed HI/LO and timing expectations.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [3:0]  e_mdu_op;
  logic [31:0] e_rs, e_rt;
  logic        d_is_mdu;
  logic [31:0] md_rdata, hi, lo;
  logic        busy, start, stall;

  int checks = 0;
  int failures = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .e_mdu_op (e_mdu_op),
    .e_rs     (e_rs),
    .e_rt     (e_rt),
    .d_is_mdu (d_is_mdu),
    .md_rdata (md_rdata),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .start    (start),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  // Advance one cycle; sample point is 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue a mult/div at the current cycle, check start, then count busy cycles.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input int exp_n, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    e_mdu_op = op; e_rs = rs; e_rt = rt;
    #1;
    checks++;
    if (start !== 1'b1) begin
      failures++;
      $display("FAIL %s start: got %b want 1", name, start);
    end
    cyc();
    e_mdu_op = 4'd0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      cyc();
    end
    checks++;
    if (n !== exp_n) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, n, exp_n);
    end
    checks++;
    if (hi !== exp_hi) begin
      failures++;
      $display("FAIL %s hi: got %h want %h", name, hi, exp_hi);
    end
    checks++;
    if (lo !== exp_lo) begin
      failures++;
      $display("FAIL %s lo: got %h want %h", name, lo, exp_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; e_mdu_op = 4'd0; e_rs = 32'd0; e_rt = 32'd0; d_is_mdu = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo);
    end
    checks++;
    if (busy !== 1'b0 || start !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got busy=%b start=%b stall=%b want 0 0 0", busy, start, stall);
    end
    d_is_mdu = 1'b0;
    cyc();
  endtask

  task automatic test_mult();
    run_op("mult", 4'd1, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu", 4'd2, 32'hFFFF_FFFD, 32'd5, 5, 32'h0000_0004, 32'hFFFF_FFF1);
    e_mdu_op = 4'd7;
    #1;
    checks++;
    if (md_rdata !== 32'h0000_0004) begin
      failures++;
      $display("FAIL mfhi: got %h want 00000004", md_rdata);
    end
    e_mdu_op = 4'd8;
    #1;
    checks++;
    if (md_rdata !== 32'hFFFF_FFF1) begin
      failures++;
      $display("FAIL mflo: got %h want fffffff1", md_rdata);
    end
    e_mdu_op = 4'd9;
    #1;
    checks++;
    if (md_rdata !== 32'd0) begin
      failures++;
      $display("FAIL rdata_other: got %h want 0", md_rdata);
    end
    e_mdu_op = 4'd0;
    cyc();
  endtask

  task automatic test_div();
    run_op("divu", 4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negdiv", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
  endtask

  task automatic test_div_zero();
    e_mdu_op = 4'd5; e_rs = 32'h1234_5678;
    cyc();
    e_mdu_op = 4'd0;
    checks++;
    if (hi !== 32'h1234_5678) begin
      failures++;
      $display("FAIL mthi: got %h want 12345678", hi);
    end
    // lo still holds the overflow quotient from the previous test.
    run_op("div_zero", 4'd3, 32'd99, 32'd0, 10, 32'h1234_5678, 32'h8000_0000);
    run_op("divu_zero", 4'd4, 32'd5, 32'd0, 10, 32'h1234_5678, 32'h8000_0000);
  endtask

  task automatic test_req();
    int seen;
    req = 1'b1; d_is_mdu = 1'b1; e_mdu_op = 4'd1; e_rs = 32'd2; e_rt = 32'd3;
    #1;
    checks++;
    if (start !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL req_start: got start=%b stall=%b want 0 0", start, stall);
    end
    cyc();
    req = 1'b0; e_mdu_op = 4'd0; d_is_mdu = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0) seen++;
      cyc();
    end
    checks++;
    if (seen !== 0 || hi !== 32'h1234_5678 || lo !== 32'h8000_0000) begin
      failures++;
      $display("FAIL req_mult: got busy_cycles=%0d hi=%h lo=%h want 0 12345678 80000000",
               seen, hi, lo);
    end
    req = 1'b1; e_mdu_op = 4'd6; e_rs = 32'hAAAA_5555;
    cyc();
    req = 1'b0; e_mdu_op = 4'd0;
    checks++;
    if (lo !== 32'h8000_0000) begin
      failures++;
      $display("FAIL req_mtlo: got %h want 80000000", lo);
    end
  endtask

  task automatic test_stall();
    int n;
    d_is_mdu = 1'b1; e_mdu_op = 4'd1; e_rs = 32'd3; e_rt = 32'd4;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL stall_start: got %b want 1", stall);
    end
    cyc();
    n = 1;
    while (stall === 1'b1 && n < 40) begin
      // Mid-window: an mthi and a new mult must both be ignored.
      e_mdu_op = (n == 2) ? 4'd5 : (n == 3) ? 4'd1 : 4'd0;
      e_rs = 32'hDEAD_BEEF;
      #1;
      if (n == 3) begin
        checks++;
        if (start !== 1'b0) begin
          failures++;
          $display("FAIL busy_start: got %b want 0", start);
        end
      end
      n++;
      cyc();
    end
    e_mdu_op = 4'd0;
    checks++;
    if (n !== 6) begin
      failures++;
      $display("FAIL stall_cycles: got %0d want 6", n);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd12) begin
      failures++;
      $display("FAIL stall_result: got %h/%h want 00000000/0000000c", hi, lo);
    end
    d_is_mdu = 1'b0;
  endtask

  task automatic test_back_to_back();
    // run_op returns in the first idle cycle, so the next start is back-to-back.
    run_op("b2b_mult", 4'd1, 32'd6, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("b2b_multu", 4'd2, 32'h0001_0000, 32'h0001_0000, 5, 32'd1, 32'd0);
  endtask

  task automatic test_reset_mid();
    e_mdu_op = 4'd5; e_rs = 32'h55;
    cyc();
    e_mdu_op = 4'd6; e_rs = 32'h66;
    cyc();
    e_mdu_op = 4'd4; e_rs = 32'd100; e_rt = 32'd7;
    cyc();
    e_mdu_op = 4'd0;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid: got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    run_op("post_reset_mult", 4'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_req();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
